// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encoding,
// control state encoding, default latencies and a small op-class helper.
package mdu_pkg;

    // Operation encoding presented on the op port.
    localparam logic [2:0] MDU_NONE = 3'd0;
    localparam logic [2:0] MULT     = 3'd1;
    localparam logic [2:0] MULTU    = 3'd2;
    localparam logic [2:0] DIV      = 3'd3;
    localparam logic [2:0] DIVU     = 3'd4;
    localparam logic [2:0] MTHI     = 3'd5;
    localparam logic [2:0] MTLO     = 3'd6;

    // Control states of the unit.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    // Default configuration.
    localparam int MDU_WIDTH_DEF       = 32;
    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    // True for operations that take the multi-cycle path.
    function automatic logic mdu_is_mul(input logic [2:0] op);
        return (op == MULT) || (op == MULTU);
    endfunction

    function automatic logic mdu_is_div(input logic [2:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. Produces the HI/LO pair for
// mult/multu/div/divu, including the divide-by-zero and signed-overflow
// results. Signed operations are done on magnitudes and re-signed, so
// only unsigned operators are instantiated.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH_DEF
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};

    logic                 a_neg_s;
    logic                 b_neg_s;
    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic                 div_zero_s;
    logic                 div_ovf_s;
    logic [WIDTH-1:0]     b_safe_s;
    logic [WIDTH-1:0]     b_mag_safe_s;
    logic [2*WIDTH-1:0]   prod_mag_s;
    logic [2*WIDTH-1:0]   prod_sgn_s;
    logic [2*WIDTH-1:0]   prod_u_s;
    logic [WIDTH-1:0]     quo_mag_s;
    logic [WIDTH-1:0]     rem_mag_s;
    logic [WIDTH-1:0]     quo_sgn_s;
    logic [WIDTH-1:0]     rem_sgn_s;
    logic [WIDTH-1:0]     quo_u_s;
    logic [WIDTH-1:0]     rem_u_s;

    assign a_neg_s = a[WIDTH-1];
    assign b_neg_s = b[WIDTH-1];
    assign a_mag_s = a_neg_s ? (~a + ONE_W) : a;
    assign b_mag_s = b_neg_s ? (~b + ONE_W) : b;

    // The divider never sees zero; the zero case is overridden below.
    assign div_zero_s   = (b == ZERO_W);
    assign div_ovf_s    = (a == MIN_W) && (b == ONES_W);
    assign b_safe_s     = div_zero_s ? ONE_W : b;
    assign b_mag_safe_s = div_zero_s ? ONE_W : b_mag_s;

    assign prod_mag_s = {ZERO_W, a_mag_s} * {ZERO_W, b_mag_s};
    assign prod_sgn_s = (a_neg_s ^ b_neg_s) ? (~prod_mag_s + {ZERO_W, ONE_W}) : prod_mag_s;
    assign prod_u_s   = {ZERO_W, a} * {ZERO_W, b};

    // Quotient truncates toward zero; remainder follows the dividend sign.
    assign quo_mag_s = a_mag_s / b_mag_safe_s;
    assign rem_mag_s = a_mag_s % b_mag_safe_s;
    assign quo_sgn_s = (a_neg_s ^ b_neg_s) ? (~quo_mag_s + ONE_W) : quo_mag_s;
    assign rem_sgn_s = a_neg_s ? (~rem_mag_s + ONE_W) : rem_mag_s;
    assign quo_u_s   = a / b_safe_s;
    assign rem_u_s   = a % b_safe_s;

    // Select the HI/LO pair for the requested operation.
    always_comb begin
        res_hi = ZERO_W;
        res_lo = ZERO_W;
        case (op)
            MULT: begin
                res_hi = prod_sgn_s[2*WIDTH-1:WIDTH];
                res_lo = prod_sgn_s[WIDTH-1:0];
            end
            MULTU: begin
                res_hi = prod_u_s[2*WIDTH-1:WIDTH];
                res_lo = prod_u_s[WIDTH-1:0];
            end
            DIV: begin
                if (div_zero_s) begin
                    res_hi = a;
                    res_lo = ONES_W;
                end else if (div_ovf_s) begin
                    res_hi = ZERO_W;
                    res_lo = MIN_W;
                end else begin
                    res_hi = rem_sgn_s;
                    res_lo = quo_sgn_s;
                end
            end
            DIVU: begin
                if (div_zero_s) begin
                    res_hi = a;
                    res_lo = ONES_W;
                end else begin
                    res_hi = rem_u_s;
                    res_lo = quo_u_s;
                end
            end
            default: begin
                res_hi = ZERO_W;
                res_lo = ZERO_W;
            end
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit holding architectural HI/LO. The result of a
// mult/div is computed in the issue cycle and parked in a pending
// register; a latency counter then holds busy high for the configured
// number of cycles before HI/LO are updated. mthi/mtlo write directly.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = MDU_WIDTH_DEF,
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

    mdu_state_e       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
    logic [WIDTH-1:0] hi_q,      hi_d;
    logic [WIDTH-1:0] lo_q,      lo_d;
    logic [WIDTH-1:0] res_hi_s;
    logic [WIDTH-1:0] res_lo_s;

    mdu_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op     (op),
        .a      (a),
        .b      (b),
        .res_hi (res_hi_s),
        .res_lo (res_lo_s)
    );

    // Next-state logic: accept new work only in IDLE, count down in RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (mdu_is_mul(op)) begin
                        pend_hi_d = res_hi_s;
                        pend_lo_d = res_lo_s;
                        cnt_d     = MULT_LOAD;
                        state_d   = RUN;
                    end else if (mdu_is_div(op)) begin
                        pend_hi_d = res_hi_s;
                        pend_lo_d = res_lo_s;
                        cnt_d     = DIV_LOAD;
                        state_d   = RUN;
                    end else if (op == MTHI) begin
                        hi_d = a;
                    end else if (op == MTLO) begin
                        lo_d = a;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Any start seen here is dropped on purpose.
                if (cnt_q == CNT_ZERO) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            pend_hi_q <= ZERO_W;
            pend_lo_q <= ZERO_W;
            hi_q      <= ZERO_W;
            lo_q      <= ZERO_W;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit. The stimulus process pushes the
// expected HI/LO and busy length of every accepted mult/div; a monitor
// pops and compares whenever busy falls, and checks HI/LO hold while busy.
// A second instance with 1-cycle latencies gets a short directed test.
module tb_mdu_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        start1;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy,  busy1;
    logic [31:0] hi,    hi1;
    logic [31:0] lo,    lo1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] cur_hi      = 32'h0;
    logic [31:0] cur_lo      = 32'h0;

    always #5 clk = ~clk;

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo));

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op), .a(a), .b(b),
        .busy(busy1), .hi(hi1), .lo(lo1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the MIPS definitions.
    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] rh, output logic [31:0] rl);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        longint      qv;
        longint      rv;
        logic [63:0] p;
        rh = 32'h0;
        rl = 32'h0;
        case (o)
            OP_MULT: begin
                p  = 64'(sx * sy);
                rh = p[63:32];
                rl = p[31:0];
            end
            OP_MULTU: begin
                p  = {32'h0, x} * {32'h0, y};
                rh = p[63:32];
                rl = p[31:0];
            end
            OP_DIV: begin
                if (y == 32'h0) begin
                    rh = x;
                    rl = 32'hFFFF_FFFF;
                end else begin
                    qv = sx / sy;
                    rv = sx % sy;
                    rh = rv[31:0];
                    rl = qv[31:0];
                end
            end
            OP_DIVU: begin
                if (y == 32'h0) begin
                    rh = x;
                    rl = 32'hFFFF_FFFF;
                end else begin
                    rh = x % y;
                    rl = x / y;
                end
            end
            default: begin
                rh = 32'h0;
                rl = 32'h0;
            end
        endcase
    endfunction

    // Returns at a negedge where the unit is idle, or reports a timeout.
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
        end
    endtask

    // Issue one op in the first idle cycle and record what it must do.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] rh;
        logic [31:0] rl;
        exp_t        e;
        wait_idle();
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        if (o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
            model(o, x, y, rh, rl);
            e.hi = rh;
            e.lo = rl;
            e.n  = (o == OP_MULT || o == OP_MULTU) ? MC : DC;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
        if (o == OP_MTHI || o == OP_MTLO) begin
            if (o == OP_MTHI) cur_hi = x;
            else              cur_lo = x;
            @(negedge clk);
            check("mt_hi", hi, cur_hi);
            check("mt_lo", lo, cur_lo);
            check("mt_busy", {31'h0, busy}, 32'h0);
        end else if (!(o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU})) begin
            @(negedge clk);
            check("nop_hi", hi, cur_hi);
            check("nop_lo", lo, cur_lo);
            check("nop_busy", {31'h0, busy}, 32'h0);
        end
    endtask

    // Drive a one-cycle start while the unit is busy; it must be ignored.
    task automatic poke(input logic [2:0] o, input logic [31:0] x);
        op     = o;
        a      = x;
        b      = $urandom;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Monitor: completion on busy falling edge, hold check while busy.
    initial begin : monitor
        int   bcnt = 0;
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                sb_q.delete();
                bcnt   = 0;
                prev   = 1'b0;
                cur_hi = 32'h0;
                cur_lo = 32'h0;
            end else begin
                if (busy === 1'b1) begin
                    bcnt++;
                    check("hold_hi", hi, cur_hi);
                    check("hold_lo", lo, cur_lo);
                end else if (prev) begin
                    if (sb_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_completion: hi %h lo %h with no op pending", hi, lo);
                    end else begin
                        e = sb_q.pop_front();
                        check("res_hi", hi, e.hi);
                        check("res_lo", lo, e.lo);
                        check("busy_len", 32'(bcnt), 32'(e.n));
                        cur_hi = e.hi;
                        cur_lo = e.lo;
                    end
                    bcnt = 0;
                end
                prev = (busy === 1'b1);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        int          sel;

        reset  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        op     = OP_NONE;
        a      = 32'h0;
        b      = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_hi1", hi1, 32'h0);
        check("rst_lo1", lo1, 32'h0);
        check("rst_busy1", {31'h0, busy1}, 32'h0);

        // Directed cases, issued back to back in the first idle cycle.
        issue(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        issue(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
        issue(OP_DIVU,  32'h0000_0007, 32'h0000_0000);
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        issue(OP_DIV,   32'h0000_0005, 32'h0000_0000);
        issue(OP_MTHI,  32'h0000_1234, 32'h0);
        @(negedge clk);
        check("mthi_nobusy", {31'h0, busy}, 32'h0);
        issue(OP_NONE,  32'hDEAD_BEEF, 32'h1);

        // MTLO in cycle 3 of a running MULT is dropped.
        issue(OP_MULT, 32'h0000_0100, 32'h0000_0200);
        @(posedge clk);
        @(posedge clk);
        #1 poke(OP_MTLO, 32'h0000_ABCD);

        // Randomised ops, some with an illegal start while busy.
        for (int i = 0; i < 60; i++) begin
            o   = 3'($urandom_range(0, 7));
            x   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       y = 32'h0;
                1:       y = 32'hFFFF_FFFF;
                2:       y = 32'($urandom_range(1, 9));
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
            issue(o, x, y);
            if ((o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) && $urandom_range(0, 3) == 0)
                poke(3'($urandom_range(1, 6)), $urandom);
        end

        // Reset in cycle 4 of a DIV: discarded, no late commit.
        issue(OP_DIV, 32'h0000_0064, 32'h0000_0007);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("postrst_hi", hi, 32'h0);
            check("postrst_lo", lo, 32'h0);
            check("postrst_busy", {31'h0, busy}, 32'h0);
        end

        // One-cycle latency instance.
        @(negedge clk);
        op = OP_MULT; a = 32'hFFFF_FFFE; b = 32'h0000_0003; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        @(negedge clk);
        check("lat1_mul_busy", {31'h0, busy1}, 32'h1);
        check("lat1_mul_hold", lo1, 32'h0);
        @(negedge clk);
        check("lat1_mul_idle", {31'h0, busy1}, 32'h0);
        check("lat1_mul_hi", hi1, 32'hFFFF_FFFF);
        check("lat1_mul_lo", lo1, 32'hFFFF_FFFA);
        op = OP_DIV; a = 32'hFFFF_FFF9; b = 32'h0000_0002; start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        @(negedge clk);
        check("lat1_div_busy", {31'h0, busy1}, 32'h1);
        @(negedge clk);
        check("lat1_div_idle", {31'h0, busy1}, 32'h0);
        check("lat1_div_hi", hi1, 32'hFFFF_FFFF);
        check("lat1_div_lo", lo1, 32'hFFFF_FFFD);

        // Everything issued must have completed.
        wait_idle();
        @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
